// File: rtl/fc2_pkg.sv
// Shared constants, state encoding and arithmetic helpers for the FC2 + argmax output stage.
package fc2_pkg;

  localparam int unsigned N_IN  = 256;
  localparam int unsigned N_OUT = 10;
  localparam int unsigned SHIFT = 2;
  localparam int unsigned ACC_W = 30;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned CLS_W = 4;

  // Classes 2 and 5 share the largest bias so an all-equal frame resolves a tie.
  localparam logic signed [15:0] BIAS [N_OUT] = '{
    16'sd40, -16'sd25, 16'sd90, 16'sd10, -16'sd60,
    16'sd90, 16'sd0,   -16'sd5, 16'sd75, 16'sd30
  };

  typedef enum logic [2:0] {StIdle, StAccum, StBias, StOutput, StDone} state_e;

  function automatic logic [9:0] relu_q(input logic signed [15:0] x, input int unsigned sh);
    logic signed [15:0] t;
    t = x >>> sh;
    if (x[15]) return 10'd0;
    if (t > 16'sd1023) return 10'd1023;
    return t[9:0];
  endfunction

  localparam logic signed [ACC_W:0] SatMax = (ACC_W+1)'(32767);
  localparam logic signed [ACC_W:0] SatMin = -(ACC_W+1)'(32768);

  function automatic logic signed [15:0] sat16(input logic signed [ACC_W:0] v);
    if (v > SatMax) return 16'sh7fff;
    if (v < SatMin) return 16'sh8000;
    return v[15:0];
  endfunction

endpackage

// File: rtl/fc2_neuron.sv
// One output neuron: signed MAC accumulator plus bias add and 16-bit saturation.
module fc2_neuron
  import fc2_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               mac_en_i,
  input  logic [9:0]         act_i,
  input  logic signed [8:0]  weight_i,
  input  logic signed [15:0] bias_i,
  output logic signed [15:0] score_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, prod;
  logic signed [ACC_W:0]   sum;

  assign prod = ACC_W'(signed'({1'b0, act_i})) * ACC_W'(weight_i);

  // Clearing and the first MAC of a frame happen in the same cycle.
  always_comb begin
    acc_d = clear_i ? '0 : acc_q;
    if (mac_en_i) acc_d = acc_d + prod;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign sum     = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(bias_i);
  assign score_o = sat16(sum);

endmodule

// File: rtl/fc2_argmax.sv
// Output layer: accumulates N_OUT class scores over a frame, streams them out, then the argmax.
module fc2_argmax
  import fc2_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic signed [15:0]     in_data_i,
  input  logic [9*N_OUT-1:0]     weight_i,
  output logic [IDX_W-1:0]       in_idx_o,
  output logic                   out_valid_o,
  output logic signed [15:0]     out_data_o,
  output logic [CLS_W-1:0]       out_idx_o,
  output logic                   class_valid_o,
  output logic [CLS_W-1:0]       class_id_o
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic               out_valid_q, class_valid_q;
  logic signed [15:0] out_data_q, max_q;
  logic [CLS_W-1:0]   out_idx_q, argmax_q, class_id_q, nxt_idx;
  logic [9:0]         act;
  logic               accept, clear;
  logic signed [15:0] score [N_OUT];

  assign in_ready_o = (state_q == StIdle) || (state_q == StAccum);
  assign accept     = in_valid_i && in_ready_o;
  assign clear      = accept && (state_q == StIdle);
  assign act        = relu_q(in_data_i, SHIFT);
  assign nxt_idx    = out_idx_q + 1'b1;

  for (genvar g = 0; g < N_OUT; g++) begin : g_neuron
    fc2_neuron u_neuron (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .clear_i  (clear),
      .mac_en_i (accept),
      .act_i    (act),
      .weight_i ($signed(weight_i[9*g +: 9])),
      .bias_i   (BIAS[g]),
      .score_o  (score[g])
    );
  end

  // Accumulators are frozen outside IDLE/ACCUM, so scores are read straight from the neurons.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_idx_q     <= '0;
      max_q         <= '0;
      argmax_q      <= '0;
      class_valid_q <= 1'b0;
      class_id_q    <= '0;
    end else begin
      class_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q   <= IDX_W'(1);
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (accept) begin
            if (idx_q == IDX_W'(N_IN - 1)) begin
              idx_q   <= '0;
              state_q <= StBias;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        StBias: begin
          out_valid_q <= 1'b1;
          out_idx_q   <= '0;
          out_data_q  <= score[0];
          max_q       <= score[0];
          argmax_q    <= '0;
          state_q     <= StOutput;
        end
        StOutput: begin
          if (out_idx_q == CLS_W'(N_OUT - 1)) begin
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            out_idx_q     <= '0;
            class_valid_q <= 1'b1;
            class_id_q    <= argmax_q;
            state_q       <= StDone;
          end else begin
            out_idx_q  <= nxt_idx;
            out_data_q <= score[nxt_idx];
            // Strictly greater keeps the lowest index on a tie.
            if (score[nxt_idx] > max_q) begin
              max_q    <= score[nxt_idx];
              argmax_q <= nxt_idx;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_idx_o      = idx_q;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_idx_o     = out_idx_q;
  assign class_valid_o = class_valid_q;
  assign class_id_o    = class_id_q;

endmodule

// File: tb/tb_fc2_argmax.sv
// Self-checking bench for fc2_argmax: ROM-fed frames, reference model scoreboard, timing checks.
module tb_fc2_argmax;
  import fc2_pkg::*;

  typedef struct packed {
    logic [N_OUT-1:0][15:0] s;
    logic [3:0]             cls;
  } exp_t;

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic [9*N_OUT-1:0] weight;
  logic [7:0]         in_idx;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic [3:0]         out_idx;
  logic               class_valid;
  logic [3:0]         class_id;

  fc2_argmax dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .in_valid_i    (in_valid),
    .in_ready_o    (in_ready),
    .in_data_i     (in_data),
    .weight_i      (weight),
    .in_idx_o      (in_idx),
    .out_valid_o   (out_valid),
    .out_data_o    (out_data),
    .out_idx_o     (out_idx),
    .class_valid_o (class_valid),
    .class_id_o    (class_id)
  );

  always #5 clk_i = ~clk_i;

  // Two ROM banks so back-to-back frames can carry different data.
  logic signed [15:0] d_rom [2][N_IN];
  logic [9*N_OUT-1:0] w_rom [2][N_IN];
  bit                 bank = 1'b0;
  assign in_data = d_rom[bank][in_idx];
  assign weight  = w_rom[bank][in_idx];

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0;
  int   valid_mode = 0;
  int   nacc = 0, exp_idx = 0, idx_err = 0, last_acc = 0;
  exp_t exp_q [$];

  logic signed [15:0] got [N_OUT];
  logic [3:0]         got_cls;
  int                 got_ov, first_ov, last_ov, cls_cyc, cls_n, rdy_err, ord_err;

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // 0: idle, 1: always valid, 2: valid every other cycle.
  initial begin
    in_valid = 1'b0;
    forever begin
      @(posedge clk_i);
      #1;
      case (valid_mode)
        1:       in_valid = 1'b1;
        2:       in_valid = ~in_valid;
        default: in_valid = 1'b0;
      endcase
    end
  end

  initial forever begin
    @(negedge clk_i);
    if (rst_ni && in_valid && in_ready) begin
      if (int'(in_idx) != exp_idx) idx_err++;
      exp_idx = (exp_idx + 1) % N_IN;
      nacc++;
      if (in_idx == 8'd255) begin
        last_acc = cyc;
        @(posedge clk_i);
        #1;
        bank = ~bank;
      end
    end
  end

  function automatic exp_t model(input bit b);
    exp_t   e;
    longint acc, s, best;
    int     dv, a, w;
    e    = '0;
    best = 0;
    for (int j = 0; j < N_OUT; j++) begin
      acc = 0;
      for (int i = 0; i < N_IN; i++) begin
        dv = int'(d_rom[b][i]);
        a  = (dv < 0) ? 0 : dv / (1 << SHIFT);
        if (a > 1023) a = 1023;
        w   = int'($signed(w_rom[b][i][9*j +: 9]));
        acc += longint'(a * w);
      end
      s = acc + longint'(BIAS[j]);
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
      e.s[j] = s[15:0];
      if (j == 0 || s > best) begin
        best  = s;
        e.cls = 4'(j);
      end
    end
    return e;
  endfunction

  task automatic fill_random(input bit b);
    for (int i = 0; i < N_IN; i++) begin
      d_rom[b][i] = 16'(int'($urandom_range(0, 8000)) - 2000);
      w_rom[b][i] = '0;
      for (int j = 0; j < N_OUT; j++) w_rom[b][i][9*j +: 9] = 9'($urandom_range(0, 511));
    end
  endtask

  task automatic fill_const(input bit b, input logic signed [15:0] d, input logic [8:0] w);
    for (int i = 0; i < N_IN; i++) begin
      d_rom[b][i] = d;
      for (int j = 0; j < N_OUT; j++) w_rom[b][i][9*j +: 9] = w;
    end
  endtask

  // Gathers one frame of DUT output; optionally stops driving once the class pulse appears.
  task automatic collect(input bit stop_after);
    for (int j = 0; j < N_OUT; j++) got[j] = 'x;
    got_cls = 'x;
    got_ov  = 0; first_ov = -1; last_ov = -1; cls_cyc = -1; cls_n = 0;
    rdy_err = 0; ord_err = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk_i);
      if (out_valid) begin
        if (int'(out_idx) != got_ov) ord_err++;
        if (in_ready) rdy_err++;
        got[out_idx] = out_data;
        if (got_ov == 0) first_ov = cyc;
        last_ov = cyc;
        got_ov++;
      end
      if (class_valid) begin
        got_cls = class_id;
        cls_cyc = cyc;
        cls_n++;
        if (stop_after) begin
          valid_mode = 0;
          in_valid   = 1'b0;
        end
        break;
      end
    end
    @(negedge clk_i);
    if (class_valid) cls_n++;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if (in_idx !== 8'd0) begin n_bad++; $display("FAIL reset_in_idx got %0d want 0", in_idx); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'sd0) begin n_bad++; $display("FAIL reset_out_data got %0d want 0", out_data); end
    n_cmp++; if (out_idx !== 4'd0) begin n_bad++; $display("FAIL reset_out_idx got %0d want 0", out_idx); end
    n_cmp++; if (class_valid !== 1'b0) begin n_bad++; $display("FAIL reset_class_valid got %b want 0", class_valid); end
    n_cmp++; if (class_id !== 4'd0) begin n_bad++; $display("FAIL reset_class_id got %0d want 0", class_id); end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_single_weight();
    exp_t e;
    fill_const(bank, 16'sd400, 9'sd1);
    exp_q.push_back(model(bank));
    valid_mode = 1;
    collect(1'b1);
    e = exp_q.pop_front();
    for (int j = 0; j < N_OUT; j++) begin
      n_cmp++;
      if (got[j] !== 16'(25600 + int'(BIAS[j])) || got[j] !== e.s[j]) begin
        n_bad++; $display("FAIL single_score[%0d] got %0d want %0d", j, got[j], $signed(e.s[j]));
      end
    end
    n_cmp++; if (got_cls !== 4'd2) begin n_bad++; $display("FAIL single_tie_class got %0d want 2", got_cls); end
    n_cmp++; if (first_ov - last_acc != 2) begin n_bad++; $display("FAIL ov_latency got %0d want 2", first_ov - last_acc); end
    n_cmp++; if (got_ov != 10 || last_ov - first_ov != 9) begin
      n_bad++; $display("FAIL ov_window got %0d beats span %0d want 10 span 9", got_ov, last_ov - first_ov);
    end
    n_cmp++; if (cls_cyc != last_ov + 1) begin n_bad++; $display("FAIL cls_follow got %0d want %0d", cls_cyc, last_ov + 1); end
    n_cmp++; if (cls_n != 1) begin n_bad++; $display("FAIL cls_pulse_len got %0d want 1", cls_n); end
    n_cmp++; if (ord_err != 0) begin n_bad++; $display("FAIL out_idx_order got %0d errors want 0", ord_err); end
  endtask

  task automatic test_relu_sat();
    exp_t e;
    fill_random(bank);
    for (int i = 0; i < N_IN; i++) d_rom[bank][i] = -16'sd5;
    exp_q.push_back(model(bank));
    valid_mode = 1;
    collect(1'b1);
    e = exp_q.pop_front();
    for (int j = 0; j < N_OUT; j++) begin
      n_cmp++;
      if (got[j] !== BIAS[j] || got[j] !== e.s[j]) begin
        n_bad++; $display("FAIL relu_score[%0d] got %0d want %0d", j, got[j], BIAS[j]);
      end
    end
    fill_const(bank, 16'sd32767, 9'sd0);
    for (int i = 0; i < N_IN; i++) w_rom[bank][i][27 +: 9] = 9'sd255;
    exp_q.push_back(model(bank));
    valid_mode = 1;
    collect(1'b1);
    e = exp_q.pop_front();
    for (int j = 0; j < N_OUT; j++) begin
      n_cmp++;
      if (got[j] !== e.s[j]) begin
        n_bad++; $display("FAIL possat_score[%0d] got %0d want %0d", j, got[j], $signed(e.s[j]));
      end
    end
    n_cmp++; if (got[3] !== 16'sd32767) begin n_bad++; $display("FAIL possat_clamp got %0d want 32767", got[3]); end
    n_cmp++; if (got_cls !== 4'd3) begin n_bad++; $display("FAIL possat_class got %0d want 3", got_cls); end
  endtask

  task automatic test_neg_sat();
    exp_t e;
    fill_const(bank, 16'sd32767, 9'sd0);
    for (int i = 0; i < N_IN; i++) w_rom[bank][i][63 +: 9] = -9'sd256;
    exp_q.push_back(model(bank));
    valid_mode = 1;
    collect(1'b1);
    e = exp_q.pop_front();
    for (int j = 0; j < N_OUT; j++) begin
      n_cmp++;
      if (got[j] !== e.s[j]) begin
        n_bad++; $display("FAIL negsat_score[%0d] got %0d want %0d", j, got[j], $signed(e.s[j]));
      end
    end
    n_cmp++; if (got[7] !== -16'sd32768) begin n_bad++; $display("FAIL negsat_clamp got %0d want -32768", got[7]); end
    n_cmp++; if (got_cls !== 4'd2) begin n_bad++; $display("FAIL negsat_class got %0d want 2", got_cls); end
  endtask

  task automatic test_gapped();
    exp_t e;
    fill_random(1'b0);
    d_rom[1] = d_rom[0];
    w_rom[1] = w_rom[0];
    for (int pass = 0; pass < 2; pass++) begin
      exp_q.push_back(model(bank));
      nacc = 0; idx_err = 0; exp_idx = 0;
      valid_mode = (pass == 0) ? 1 : 2;
      collect(1'b1);
      e = exp_q.pop_front();
      for (int j = 0; j < N_OUT; j++) begin
        n_cmp++;
        if (got[j] !== e.s[j]) begin
          n_bad++; $display("FAIL gap%0d_score[%0d] got %0d want %0d", pass, j, got[j], $signed(e.s[j]));
        end
      end
      n_cmp++; if (got_cls !== e.cls) begin n_bad++; $display("FAIL gap%0d_class got %0d want %0d", pass, got_cls, e.cls); end
      n_cmp++; if (nacc != N_IN) begin n_bad++; $display("FAIL gap%0d_beats got %0d want %0d", pass, nacc, N_IN); end
      n_cmp++; if (idx_err != 0) begin n_bad++; $display("FAIL gap%0d_in_idx_seq got %0d errors want 0", pass, idx_err); end
      n_cmp++; if (rdy_err != 0) begin n_bad++; $display("FAIL gap%0d_ready_in_output got %0d want 0", pass, rdy_err); end
      n_cmp++; if (in_idx !== 8'd0) begin n_bad++; $display("FAIL gap%0d_idx_wrap got %0d want 0", pass, in_idx); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int ov_seen;
    fill_random(bank);
    nacc = 0;
    valid_mode = 1;
    for (int c = 0; c < 1000 && nacc < 100; c++) @(negedge clk_i);
    valid_mode = 0;
    in_valid   = 1'b0;
    rst_ni     = 1'b0;
    #1;
    n_cmp++; if (in_idx !== 8'd0) begin n_bad++; $display("FAIL abort_in_idx got %0d want 0", in_idx); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL abort_in_ready got %b want 1", in_ready); end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    ov_seen = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (out_valid || class_valid) ov_seen++;
    end
    n_cmp++; if (ov_seen != 0) begin n_bad++; $display("FAIL abort_output got %0d cycles want 0", ov_seen); end
    exp_idx = 0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cls_a;
    fill_random(~bank);
    exp_q.push_back(model(bank));
    exp_q.push_back(model(~bank));
    idx_err = 0;
    valid_mode = 1;
    for (int f = 0; f < 2; f++) begin
      collect(f == 1);
      e = exp_q.pop_front();
      for (int j = 0; j < N_OUT; j++) begin
        n_cmp++;
        if (got[j] !== e.s[j]) begin
          n_bad++; $display("FAIL b2b%0d_score[%0d] got %0d want %0d", f, j, got[j], $signed(e.s[j]));
        end
      end
      n_cmp++; if (got_cls !== e.cls) begin n_bad++; $display("FAIL b2b%0d_class got %0d want %0d", f, got_cls, e.cls); end
      n_cmp++; if (cls_n != 1) begin n_bad++; $display("FAIL b2b%0d_cls_pulses got %0d want 1", f, cls_n); end
      if (f == 0) cls_a = cls_cyc;
    end
    n_cmp++; if (last_acc - cls_a != 256) begin
      n_bad++; $display("FAIL b2b_restart got %0d want 256", last_acc - cls_a);
    end
    n_cmp++; if (idx_err != 0) begin n_bad++; $display("FAIL b2b_in_idx_seq got %0d errors want 0", idx_err); end
  endtask

  initial begin
    for (int b = 0; b < 2; b++) fill_const(1'(b), 16'sd0, 9'sd0);
    test_reset();
    test_single_weight();
    test_relu_sat();
    test_neg_sat();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got %0d want 0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
